ysyx_23060208_mem_arbiter: RTL and testbench
============================================

Name: ysyx_23060208_mem_arbiter

Overview:
- Sits directly downstream of the core's fetch unit (IFU) and load/store unit (LSU).
- Merges their two memory request streams onto one shared memory port.
- Uses a valid/ready request handshake and a one-cycle response pulse, so the shared memory model can replace the separate instruction and data SRAMs.
- One transaction outstanding at a time; responses are routed back to the master that issued the request.

Parameters:
- DATA_WIDTH, 32, address and data width.
- STRB_WIDTH, DATA_WIDTH/8, write byte-strobe width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ifu_req_valid  in  1  IFU request valid.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  DATA_WIDTH  IFU fetch address (IFU is read-only).
- ifu_resp_valid  out  1  IFU response pulse.
- ifu_rdata  out  DATA_WIDTH  instruction word.
- lsu_req_valid  in  1  LSU request valid.
- lsu_req_ready  out  1  LSU request accepted.
- lsu_addr  in  DATA_WIDTH  LSU address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  DATA_WIDTH  store data.
- lsu_wstrb  in  STRB_WIDTH  store byte enables.
- lsu_resp_valid  out  1  LSU response pulse (load data or store ack).
- lsu_rdata  out  DATA_WIDTH  load data.
- mem_req_valid  out  1  request to shared memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  DATA_WIDTH  forwarded address.
- mem_wen  out  1  forwarded write enable.
- mem_wdata  out  DATA_WIDTH  forwarded write data.
- mem_wstrb  out  STRB_WIDTH  forwarded strobes.
- mem_resp_valid  in  1  memory response pulse (read data or write ack).
- mem_rdata  in  DATA_WIDTH  memory read data.

Behaviour:
- Clock and reset: clk is the only clock; rst is synchronous and active-high.
- FSM states: IDLE, REQ_IFU, REQ_LSU, RESP_IFU, RESP_LSU. Reset state is IDLE.
- Reset outputs: all *_valid, *_ready and mem_wen are 0; data, address and strobe outputs are 0.
- IDLE:
  - No requests: stay in IDLE.
  - Only one master requesting: go to that master's REQ state.
  - Both requesting: LSU wins (fixed priority).
  - No ready is given in IDLE.
- Grant latency: the grant is registered, so the earliest mem_req_valid is the cycle after the master raises valid.
- REQ_x:
  - mem_req_valid = x_req_valid.
  - mem_addr, mem_wen, mem_wdata and mem_wstrb are combinationally forwarded from master x.
  - For IFU: mem_wen = 0, mem_wdata = 0, mem_wstrb = 0.
  - x_req_ready = mem_req_ready. The other master's ready is 0.
  - On the handshake (valid & ready): go to RESP_x.
- RESP_x:
  - mem_req_valid = 0.
  - On mem_resp_valid: x_resp_valid = 1 for exactly that cycle, x_rdata = mem_rdata, then go to IDLE.
- Same-cycle response:
  - If mem_resp_valid is asserted in the same cycle as the REQ_x handshake, route the response to x that cycle and go straight to IDLE.
- rdata hold: x_rdata is registered-through. It holds its last value when x_resp_valid = 0 and is never driven with the other master's data.
- Stray responses: mem_resp_valid in IDLE or in REQ_x without a handshake is ignored; no response pulse is generated.
- Master protocol: a master must hold valid and its payload stable until ready. Deassertion before ready is a protocol violation. The arbiter keeps the grant until the handshake (no timeout).
- Back-to-back: minimum spacing between two grants is 1 IDLE cycle.
- Reset mid-transaction: on rst, return to IDLE immediately and drop the in-flight transaction; no response is delivered to either master.
- Pending requester: a master requesting while the other holds the grant is stalled (ready = 0) and arbitrates at the next IDLE.

Optional Feature:
- Macro: MEM_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_grant register (reset to IFU) records the last granted master.
  - On a simultaneous request in IDLE, the master not in last_grant wins.
  - last_grant updates on every REQ_x handshake.
- Undefined: fixed LSU priority as described in Behaviour; no last_grant register.

Decomposition:
- Shared package ysyx_23060208_mem_pkg holds:
  - the state enum (IDLE, REQ_IFU, REQ_LSU, RESP_IFU, RESP_LSU);
  - master-ID constants MST_IFU = 0 and MST_LSU = 1;
  - the request payload struct {addr, wen, wdata, wstrb}.
- One sub-module is natural: ysyx_23060208_arb_sel, a combinational winner select taking the two valids plus last_grant and returning the winning ID. It is the only piece that changes under the macro.

Test Plan:
- Single IFU read:
  - Stimulus: ifu_req_valid = 1, addr 0x80000000; memory ready after 2 cycles and returns 0x00000413 one cycle after accept.
  - Required: mem_req_valid rises the cycle after the request; ifu_req_ready pulses with mem_req_ready; ifu_resp_valid = 1 for one cycle with ifu_rdata = 0x00000413; lsu_resp_valid stays 0.
- Simultaneous requests:
  - Stimulus: IFU addr 0x80000004 and LSU load addr 0x80001000 in the same cycle.
  - Required: LSU is served first (mem_addr = 0x80001000), then IFU (mem_addr = 0x80000004). With MEM_ARBITER_ROUND_ROBIN_EN and last_grant = IFU, the LSU is also served first; on a second simultaneous pair, IFU is served first.
- LSU store:
  - Stimulus: wen = 1, addr 0x80002000, wdata 0xDEADBEEF, wstrb 4'b0011.
  - Required: the mem_* outputs match exactly; lsu_resp_valid pulses on the memory ack.
- Same-cycle response:
  - Stimulus: memory asserts mem_req_ready and mem_resp_valid together, rdata 0x12345678.
  - Required: lsu_resp_valid = 1 that cycle with rdata 0x12345678; the FSM is in IDLE the next cycle.
- Reset in RESP_IFU:
  - Stimulus: assert rst for 1 cycle while the IFU response is pending; memory then asserts mem_resp_valid.
  - Required: the FSM returns to IDLE; ifu_resp_valid stays 0; the stray response is ignored.
- Stray response in IDLE:
  - Stimulus: mem_resp_valid = 1 with no request pending.
  - Required: both resp_valid outputs stay 0 and the state is unchanged.

Source files
------------

// File: rtl/ysyx_23060208_mem_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter.
// Holds the arbiter state encoding, the master IDs and the request payload
// struct used to carry one master's request onto the shared memory port.
package ysyx_23060208_mem_pkg;

  localparam int MEM_DW = 32;
  localparam int MEM_SW = MEM_DW / 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ_IFU  = 3'd1,
    ST_REQ_LSU  = 3'd2,
    ST_RESP_IFU = 3'd3,
    ST_RESP_LSU = 3'd4
  } arb_state_e;

  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

  typedef struct packed {
    logic [MEM_DW-1:0] addr;
    logic              wen;
    logic [MEM_DW-1:0] wdata;
    logic [MEM_SW-1:0] wstrb;
  } mem_req_t;

  // Idle value of the forwarded request channel.
  localparam mem_req_t REQ_NONE = '{addr: 32'h0, wen: 1'b0, wdata: 32'h0, wstrb: 4'h0};

endpackage

// File: rtl/ysyx_23060208_arb_sel.sv
// Winner select for the memory arbiter (purely combinational).
// Ports:
//   ifu_valid  - IFU is requesting
//   lsu_valid  - LSU is requesting
//   last_grant - master granted most recently (only used for round-robin)
//   winner     - ID of the master to grant (MST_IFU / MST_LSU)
// Build option: MEM_ARBITER_ROUND_ROBIN_EN switches simultaneous requests
// from fixed LSU priority to alternating on last_grant.
module ysyx_23060208_arb_sel
  import ysyx_23060208_mem_pkg::*;
(
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic last_grant,
  output logic winner
);

  // Pick the winner; a lone requester always wins.
  always_comb begin
    winner = MST_LSU;
    if (ifu_valid && lsu_valid) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      winner = ~last_grant;
`else
      winner = MST_LSU;
`endif
    end else if (ifu_valid) begin
      winner = MST_IFU;
    end else begin
      winner = MST_LSU;
    end
  end

`ifndef MEM_ARBITER_ROUND_ROBIN_EN
  // Fixed priority ignores the grant history.
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant;
`endif

endmodule

// File: rtl/ysyx_23060208_mem_arbiter.sv
// Merges the IFU (read-only) and LSU request streams onto one shared memory
// port with a single transaction outstanding at a time.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   ifu_req_valid/ready      - IFU request handshake, ifu_addr fetch address
//   ifu_resp_valid/ifu_rdata - IFU response pulse and instruction word
//   lsu_req_valid/ready      - LSU request handshake with addr/wen/wdata/wstrb
//   lsu_resp_valid/lsu_rdata - LSU response pulse (load data or store ack)
//   mem_req_valid/ready      - shared memory request with forwarded payload
//   mem_resp_valid/mem_rdata - shared memory response pulse and read data
// Build option: MEM_ARBITER_ROUND_ROBIN_EN adds a last_grant register and
// alternates the winner on simultaneous requests.
module ysyx_23060208_mem_arbiter
  import ysyx_23060208_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [DATA_WIDTH-1:0] ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [DATA_WIDTH-1:0] lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [STRB_WIDTH-1:0] lsu_wstrb,
  output logic                  lsu_resp_valid,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0] mem_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  arb_state_e            state_r;
  logic [DATA_WIDTH-1:0] ifu_rdata_r;
  logic [DATA_WIDTH-1:0] lsu_rdata_r;
  logic                  grant_hist_s;
  logic                  winner_s;
  mem_req_t              ifu_pl_s;
  mem_req_t              lsu_pl_s;
  mem_req_t              fwd_s;
  logic                  ifu_hs_s;
  logic                  lsu_hs_s;
  logic                  ifu_resp_s;
  logic                  lsu_resp_s;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_grant_r;
  assign grant_hist_s = last_grant_r;
`else
  assign grant_hist_s = MST_IFU;
`endif

  ysyx_23060208_arb_sel u_arb_sel (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_grant (grant_hist_s),
    .winner     (winner_s)
  );

  // Pack each master's request; the IFU never writes.
  always_comb begin
    ifu_pl_s       = REQ_NONE;
    ifu_pl_s.addr  = ifu_addr;
    lsu_pl_s.addr  = lsu_addr;
    lsu_pl_s.wen   = lsu_wen;
    lsu_pl_s.wdata = lsu_wdata;
    lsu_pl_s.wstrb = lsu_wstrb;
  end

  // Route the granted master to memory and steer response pulses; a reset
  // cycle blanks everything so an in-flight response is never delivered.
  always_comb begin
    fwd_s         = REQ_NONE;
    mem_req_valid = 1'b0;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_hs_s      = 1'b0;
    lsu_hs_s      = 1'b0;
    ifu_resp_s    = 1'b0;
    lsu_resp_s    = 1'b0;
    if (rst) begin
      fwd_s = REQ_NONE;
    end else begin
      case (state_r)
        ST_REQ_IFU: begin
          fwd_s         = ifu_pl_s;
          mem_req_valid = ifu_req_valid;
          ifu_req_ready = mem_req_ready;
          ifu_hs_s      = ifu_req_valid & mem_req_ready;
          // A response in the accept cycle belongs to this transaction.
          ifu_resp_s    = ifu_req_valid & mem_req_ready & mem_resp_valid;
        end
        ST_REQ_LSU: begin
          fwd_s         = lsu_pl_s;
          mem_req_valid = lsu_req_valid;
          lsu_req_ready = mem_req_ready;
          lsu_hs_s      = lsu_req_valid & mem_req_ready;
          lsu_resp_s    = lsu_req_valid & mem_req_ready & mem_resp_valid;
        end
        ST_RESP_IFU: ifu_resp_s = mem_resp_valid;
        ST_RESP_LSU: lsu_resp_s = mem_resp_valid;
        default:     fwd_s      = REQ_NONE;
      endcase
    end
  end

  assign mem_addr       = fwd_s.addr;
  assign mem_wen        = fwd_s.wen;
  assign mem_wdata      = fwd_s.wdata;
  assign mem_wstrb      = fwd_s.wstrb;
  assign ifu_resp_valid = ifu_resp_s;
  assign lsu_resp_valid = lsu_resp_s;
  // Read data passes straight through on the pulse and holds afterwards.
  assign ifu_rdata      = ifu_resp_s ? mem_rdata : ifu_rdata_r;
  assign lsu_rdata      = lsu_resp_s ? mem_rdata : lsu_rdata_r;

  // Arbiter FSM, grant history and held read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ifu_rdata_r <= {DATA_WIDTH{1'b0}};
      lsu_rdata_r <= {DATA_WIDTH{1'b0}};
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_grant_r <= MST_IFU;
`endif
    end else begin
      if (ifu_resp_s) ifu_rdata_r <= mem_rdata;
      else            ifu_rdata_r <= ifu_rdata_r;
      if (lsu_resp_s) lsu_rdata_r <= mem_rdata;
      else            lsu_rdata_r <= lsu_rdata_r;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      if (ifu_hs_s)      last_grant_r <= MST_IFU;
      else if (lsu_hs_s) last_grant_r <= MST_LSU;
      else               last_grant_r <= last_grant_r;
`endif
      case (state_r)
        ST_IDLE: begin
          if (ifu_req_valid || lsu_req_valid)
            state_r <= (winner_s == MST_LSU) ? ST_REQ_LSU : ST_REQ_IFU;
          else
            state_r <= ST_IDLE;
        end
        ST_REQ_IFU: begin
          if (ifu_hs_s) state_r <= mem_resp_valid ? ST_IDLE : ST_RESP_IFU;
          else          state_r <= ST_REQ_IFU;
        end
        ST_REQ_LSU: begin
          if (lsu_hs_s) state_r <= mem_resp_valid ? ST_IDLE : ST_RESP_LSU;
          else          state_r <= ST_REQ_LSU;
        end
        ST_RESP_IFU: begin
          if (mem_resp_valid) state_r <= ST_IDLE;
          else                state_r <= ST_RESP_IFU;
        end
        ST_RESP_LSU: begin
          if (mem_resp_valid) state_r <= ST_IDLE;
          else                state_r <= ST_RESP_LSU;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_mem_arbiter.sv
// Self-checking bench for ysyx_23060208_mem_arbiter: directed scenarios
// followed by randomized request mixes, checked against a transaction-level
// model (who is served next, which data each master last received).
module tb_ysyx_23060208_mem_arbiter;
  import ysyx_23060208_mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state: last data delivered per master, last granted master.
  logic [31:0] hold [2];
  logic        model_last;

  ysyx_23060208_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic rdy_of(input logic m);
    return (m == MST_LSU) ? lsu_req_ready : ifu_req_ready;
  endfunction

  function automatic logic resp_of(input logic m);
    return (m == MST_LSU) ? lsu_resp_valid : ifu_resp_valid;
  endfunction

  function automatic logic [31:0] rdata_of(input logic m);
    return (m == MST_LSU) ? lsu_rdata : ifu_rdata;
  endfunction

  // Which master the arbitration rule serves for a request mask (bit0 IFU, bit1 LSU).
  function automatic logic pick(input logic [1:0] mask);
    if (mask == 2'b01) return MST_IFU;
    if (mask == 2'b10) return MST_LSU;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    return ~model_last;
`else
    return MST_LSU;
`endif
  endfunction

  task automatic check_resp(input logic m, input logic [31:0] rd);
    check("resp_pulse", resp_of(m), 1'b1);
    check("resp_rdata", rdata_of(m), rd);
    check("other_resp_low", resp_of(~m), 1'b0);
    check("other_rdata_hold", rdata_of(~m), hold[~m]);
    hold[m] = rd;
  endtask

  // Serve one granted transaction for master m. Entered just after a rising edge.
  task automatic serve_one(input logic m, input int exp_wait, input int rdy_dly,
                           input int rsp_dly, input logic [31:0] rd);
    int waited;
    logic [31:0] e_addr, e_wdata;
    logic        e_wen;
    logic [3:0]  e_wstrb;
    if (m == MST_LSU) begin
      e_addr = lsu_addr; e_wen = lsu_wen; e_wdata = lsu_wdata; e_wstrb = lsu_wstrb;
    end else begin
      e_addr = ifu_addr; e_wen = 1'b0; e_wdata = 32'h0; e_wstrb = 4'h0;
    end
    waited = 0;
    @(negedge clk);
    while (mem_req_valid !== 1'b1 && waited < 6) begin
      @(posedge clk); #1; waited++; @(negedge clk);
    end
    check("grant_latency", waited, exp_wait);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wen", mem_wen, e_wen);
    check("mem_wdata", mem_wdata, e_wdata);
    check("mem_wstrb", mem_wstrb, e_wstrb);
    check("other_ready_low", rdy_of(~m), 1'b0);
    for (int i = 0; i < rdy_dly; i++) begin
      mem_resp_valid = ($urandom_range(0, 1) == 1);
      mem_rdata = $urandom;
      #1;
      check("stall_ready", rdy_of(m), 1'b0);
      check("stray_resp_ifu", ifu_resp_valid, 1'b0);
      check("stray_resp_lsu", lsu_resp_valid, 1'b0);
      check("stall_rdata_hold", rdata_of(m), hold[m]);
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      @(negedge clk);
      check("req_held", mem_req_valid, 1'b1);
    end
    mem_req_ready = 1'b1;
    if (rsp_dly == 0) begin
      mem_resp_valid = 1'b1;
      mem_rdata = rd;
    end else begin
      mem_rdata = $urandom;
    end
    #1;
    check("ready_pulse", rdy_of(m), 1'b1);
    check("other_ready", rdy_of(~m), 1'b0);
    if (rsp_dly == 0) check_resp(m, rd);
    else check("no_early_resp", resp_of(m), 1'b0);
    model_last = m;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    if (m == MST_LSU) lsu_req_valid = 1'b0;
    else ifu_req_valid = 1'b0;
    if (rsp_dly > 0) begin
      for (int j = 1; j < rsp_dly; j++) begin
        @(negedge clk);
        check("resp_wait_mem_idle", mem_req_valid, 1'b0);
        check("resp_wait_no_pulse", resp_of(m), 1'b0);
        @(posedge clk); #1;
      end
      @(negedge clk);
      mem_resp_valid = 1'b1;
      mem_rdata = rd;
      #1;
      check_resp(m, rd);
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
    end
    @(negedge clk);
    check("idle_gap", mem_req_valid, 1'b0);
    check("pulse_end_ifu", ifu_resp_valid, 1'b0);
    check("pulse_end_lsu", lsu_resp_valid, 1'b0);
    check("rdata_hold", rdata_of(m), hold[m]);
    @(posedge clk); #1;
  endtask

  // Raise the requests in mask together and serve them in model order.
  task automatic run_case(input logic [1:0] mask, input logic [31:0] ia, input logic [31:0] la,
                          input logic we, input logic [31:0] wd, input logic [3:0] ws,
                          input int rdy0, input int rsp0, input logic [31:0] rd0,
                          input int rdy1, input int rsp1, input logic [31:0] rd1);
    logic first;
    @(posedge clk); #1;
    ifu_req_valid = mask[0]; ifu_addr = ia;
    lsu_req_valid = mask[1]; lsu_addr = la; lsu_wen = we; lsu_wdata = wd; lsu_wstrb = ws;
    first = pick(mask);
    serve_one(first, 1, rdy0, rsp0, rd0);
    if (mask == 2'b11) serve_one(~first, 0, rdy1, rsp1, rd1);
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_addr = 32'h0;
    lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wstrb = 4'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    hold[0] = 32'h0; hold[1] = 32'h0;
    model_last = MST_IFU;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_ifu_ready", ifu_req_ready, 1'b0);
    check("rst_lsu_ready", lsu_req_ready, 1'b0);
    check("rst_ifu_resp", ifu_resp_valid, 1'b0);
    check("rst_lsu_resp", lsu_resp_valid, 1'b0);
    check("rst_mem_wen", mem_wen, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wstrb", mem_wstrb, 4'h0);
    check("rst_ifu_rdata", ifu_rdata, 32'h0);
    check("rst_lsu_rdata", lsu_rdata, 32'h0);

    // Single IFU read: ready after 2 cycles, data one cycle after accept.
    run_case(2'b01, 32'h8000_0000, 32'h1111_1111, 1'b1, 32'h2222_2222, 4'hF,
             2, 1, 32'h0000_0413, 0, 0, 32'h0);
    // Simultaneous IFU fetch and LSU load.
    run_case(2'b11, 32'h8000_0004, 32'h8000_1000, 1'b0, 32'h0, 4'h0,
             1, 1, 32'hA5A5_0001, 0, 2, 32'h0000_0093);
    // LSU store.
    run_case(2'b10, 32'h0, 32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 4'b0011,
             0, 2, 32'h0, 0, 0, 32'h0);
    // Same-cycle accept and response.
    run_case(2'b10, 32'h0, 32'h8000_3000, 1'b0, 32'h0, 4'h0,
             0, 0, 32'h1234_5678, 0, 0, 32'h0);
    // Second simultaneous pair (last grant is now the LSU).
    run_case(2'b11, 32'h8000_0008, 32'h8000_1004, 1'b0, 32'h0, 4'h0,
             0, 1, 32'h0BAD_F00D, 1, 0, 32'h5555_AAAA);

    // Reset while the IFU response is pending.
    @(posedge clk); #1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
    @(posedge clk); #1;
    mem_req_ready = 1'b1;
    @(negedge clk);
    check("rst_case_ready", ifu_req_ready, 1'b1);
    @(posedge clk); #1;
    mem_req_ready = 1'b0; ifu_req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_case_no_resp", ifu_resp_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    hold[0] = 32'h0; hold[1] = 32'h0; model_last = MST_IFU;
    @(negedge clk);
    check("rst_stray_ifu", ifu_resp_valid, 1'b0);
    check("rst_stray_lsu", lsu_resp_valid, 1'b0);
    check("rst_ifu_rdata_clr", ifu_rdata, 32'h0);
    check("rst_mem_idle", mem_req_valid, 1'b0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    run_case(2'b01, 32'h8000_0014, 32'h0, 1'b0, 32'h0, 4'h0,
             0, 1, 32'h0000_0513, 0, 0, 32'h0);

    // Stray responses while idle.
    mem_resp_valid = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    check("idle_stray_ifu", ifu_resp_valid, 1'b0);
    check("idle_stray_lsu", lsu_resp_valid, 1'b0);
    check("idle_stray_ifu_rdata", ifu_rdata, hold[0]);
    check("idle_stray_lsu_rdata", lsu_rdata, hold[1]);
    check("idle_stray_no_req", mem_req_valid, 1'b0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    run_case(2'b10, 32'h0, 32'h8000_4000, 1'b0, 32'h0, 4'h0,
             1, 1, 32'h7777_0001, 0, 0, 32'h0);

    // Randomized request mixes.
    for (int k = 0; k < 40; k++) begin
      run_case(2'($urandom_range(1, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)),
               $urandom, 4'($urandom),
               $urandom_range(0, 2), $urandom_range(0, 2), $urandom,
               $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
